// File: rtl/key_sw_conditioner.sv
// key_sw_conditioner: two-flop synchronizers for KEY/SW plus a per-key debounce FSM
// producing level, press and release outputs. Optional auto-repeat via `define KEY_REPEAT_EN.
`default_nettype none

module key_sw_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] sw_sync,
    output logic [3:0] key_level,
    output logic [3:0] key_press,
    output logic [3:0] key_release
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    localparam logic [1:0] ST_RELEASED      = 2'd0;
    localparam logic [1:0] ST_CHECK_PRESS   = 2'd1;
    localparam logic [1:0] ST_PRESSED       = 2'd2;
    localparam logic [1:0] ST_CHECK_RELEASE = 2'd3;

    logic [3:0]    key_meta_q, key_meta_d, key_sync_q, key_sync_d;
    logic [9:0]    sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
    logic [1:0]    state_q [4];
    logic [1:0]    state_d [4];
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic [3:0]    level_q, level_d, press_q, press_d, release_q, release_d;

`ifdef KEY_REPEAT_EN
    localparam logic [15:0] RPT_DELAY  = 16'(REPEAT_DELAY);
    localparam logic [15:0] RPT_PERIOD = 16'(REPEAT_PERIOD);

    // Counts held cycles in PRESSED; arm selects first-delay vs. period target.
    logic [15:0] rpt_q [4];
    logic [15:0] rpt_d [4];
    logic [3:0]  rpt_arm_q, rpt_arm_d;
    logic [15:0] rpt_next;
`else
    logic unused_cfg;
    assign unused_cfg = (REPEAT_DELAY == REPEAT_PERIOD);
`endif

    always_comb begin
        key_meta_d = KEY;
        key_sync_d = key_meta_q;
        sw_meta_d  = SW;
        sw_sync_d  = sw_meta_q;
`ifdef KEY_REPEAT_EN
        rpt_next   = '0;
        rpt_arm_d  = '0;
`endif
        for (int k = 0; k < 4; k++) begin
            state_d[k]   = state_q[k];
            cnt_d[k]     = cnt_q[k];
            press_d[k]   = 1'b0;
            release_d[k] = 1'b0;
`ifdef KEY_REPEAT_EN
            rpt_d[k]     = '0;
`endif
            case (state_q[k])
                ST_RELEASED: begin
                    if (!key_sync_q[k]) begin
                        state_d[k] = ST_CHECK_PRESS;
                        cnt_d[k]   = CNT_ONE;
                    end else begin
                        cnt_d[k]   = '0;
                    end
                end
                ST_CHECK_PRESS: begin
                    if (key_sync_q[k]) begin
                        state_d[k] = ST_RELEASED;
                        cnt_d[k]   = '0;
                    end else if (cnt_q[k] == CNT_LAST) begin
                        state_d[k] = ST_PRESSED;
                        cnt_d[k]   = '0;
                        press_d[k] = 1'b1;
                    end else begin
                        cnt_d[k]   = cnt_q[k] + CNT_ONE;
                    end
                end
                ST_PRESSED: begin
                    if (key_sync_q[k]) begin
                        state_d[k] = ST_CHECK_RELEASE;
                        cnt_d[k]   = CNT_ONE;
                    end else begin
                        cnt_d[k]   = '0;
`ifdef KEY_REPEAT_EN
                        rpt_next = rpt_q[k] + 16'd1;
                        if (rpt_next == (rpt_arm_q[k] ? RPT_PERIOD : RPT_DELAY)) begin
                            press_d[k]   = 1'b1;
                            rpt_d[k]     = '0;
                            rpt_arm_d[k] = 1'b1;
                        end else begin
                            rpt_d[k]     = rpt_next;
                            rpt_arm_d[k] = rpt_arm_q[k];
                        end
`endif
                    end
                end
                ST_CHECK_RELEASE: begin
                    if (!key_sync_q[k]) begin
                        state_d[k]   = ST_PRESSED;
                        cnt_d[k]     = '0;
                    end else if (cnt_q[k] == CNT_LAST) begin
                        state_d[k]   = ST_RELEASED;
                        cnt_d[k]     = '0;
                        release_d[k] = 1'b1;
                    end else begin
                        cnt_d[k]     = cnt_q[k] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[k] = ST_RELEASED;
                    cnt_d[k]   = '0;
                end
            endcase
            level_d[k] = (state_d[k] == ST_PRESSED) || (state_d[k] == ST_CHECK_RELEASE);
        end
    end

    // KEY synchronizers reset to 1 so a reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta_q <= '1;
            key_sync_q <= '1;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            level_q    <= '0;
            press_q    <= '0;
            release_q  <= '0;
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= ST_RELEASED;
                cnt_q[k]   <= '0;
            end
        end else begin
            key_meta_q <= key_meta_d;
            key_sync_q <= key_sync_d;
            sw_meta_q  <= sw_meta_d;
            sw_sync_q  <= sw_sync_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_arm_q <= '0;
            for (int k = 0; k < 4; k++) rpt_q[k] <= '0;
        end else begin
            rpt_arm_q <= rpt_arm_d;
            for (int k = 0; k < 4; k++) rpt_q[k] <= rpt_d[k];
        end
    end
`endif

    assign sw_sync     = sw_sync_q;
    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

`default_nettype wire

// File: tb/tb_key_sw_conditioner.sv
// Scoreboard bench for key_sw_conditioner: a per-edge behavioural model pushes expected
// outputs; a monitor pops and compares them 1 ns after every rising edge.
`default_nettype none

module tb_key_sw_conditioner;

    localparam int D      = 4;
    localparam int DELAY  = 16;
    localparam int PERIOD = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] KEY = 4'hF;
    logic [9:0] SW = '0;
    logic [9:0] sw_sync;
    logic [3:0] key_level, key_press, key_release;

    key_sw_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (DELAY),
        .REPEAT_PERIOD  (PERIOD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .KEY        (KEY),
        .SW         (SW),
        .sw_sync    (sw_sync),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] sw;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: raw inputs delayed two edges; a key's accepted level flips once
    // the synchronized value has disagreed with it on D consecutive edges.
    logic [3:0] m_k1, m_k2, m_lvl;
    logic [9:0] m_s1, m_s2;
    int         m_run  [4];
    int         m_hold [4];

    always @(posedge clk) begin
        exp_t e;
        e.prs = '0;
        e.rel = '0;
        if (!rst_n) begin
            m_k1 = '1; m_k2 = '1; m_s1 = '0; m_s2 = '0; m_lvl = '0;
            for (int k = 0; k < 4; k++) begin m_run[k] = 0; m_hold[k] = 0; end
            e.sw = '0;
            e.lvl = '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if ((m_k2[k] == 1'b0) != m_lvl[k]) begin
                    m_run[k]++;
                    m_hold[k] = 0;
                    if (m_run[k] == D) begin
                        m_lvl[k] = ~m_lvl[k];
                        m_run[k] = 0;
                        if (m_lvl[k]) e.prs[k] = 1'b1;
                        else          e.rel[k] = 1'b1;
                    end
                end else begin
                    if (m_lvl[k] && m_run[k] == 0) begin
`ifdef KEY_REPEAT_EN
                        m_hold[k]++;
                        if (m_hold[k] >= DELAY && (m_hold[k] - DELAY) % PERIOD == 0)
                            e.prs[k] = 1'b1;
`endif
                    end else begin
                        m_hold[k] = 0;
                    end
                    m_run[k] = 0;
                end
            end
            m_k2 = m_k1; m_k1 = KEY;
            m_s2 = m_s1; m_s1 = SW;
            e.sw  = m_s2;
            e.lvl = m_lvl;
        end
        sb_q.push_back(e);
    end

    task automatic chk(input string name, input logic [9:0] got, input logic [9:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty t=%0t got=0 want>=1", $time);
        end else begin
            e = sb_q.pop_front();
            chk("sw_sync",     sw_sync,                  e.sw);
            chk("key_level",   {6'd0, key_level},        {6'd0, e.lvl});
            chk("key_press",   {6'd0, key_press},        {6'd0, e.prs});
            chk("key_release", {6'd0, key_release},      {6'd0, e.rel});
            chk("press_and_release", {6'd0, key_press & key_release}, 10'd0);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset with all keys held and all switches up.
        KEY = 4'h0; SW = 10'h3FF; rst_n = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(10);
        KEY = 4'hF;
        cycles(10);
        // Clean press and release on KEY[0].
        KEY[0] = 1'b0; cycles(20);
        KEY[0] = 1'b1; cycles(12);
        // Short bounce on KEY[1].
        KEY[1] = 1'b0; cycles(3);
        KEY[1] = 1'b1; cycles(10);
        // Reset mid-debounce on KEY[2] while still held.
        KEY[2] = 1'b0; cycles(4);
        rst_n = 1'b0; cycles(1);
        rst_n = 1'b1; cycles(12);
        KEY[2] = 1'b1; cycles(10);
        // Long hold on KEY[3].
        KEY[3] = 1'b0; cycles(40);
        KEY[3] = 1'b1; cycles(10);
        // Switch path with concurrent key activity.
        SW = 10'h155; KEY[0] = 1'b0; cycles(5);
        SW = 10'h2AA; KEY[1] = 1'b0; cycles(5);
        KEY = 4'hF; cycles(10);
        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 5) == 0) KEY[k] = ~KEY[k];
            if ($urandom_range(0, 3) == 0) SW = 10'($urandom);
            rst_n = ($urandom_range(0, 499) != 0);
            cycles(1);
        end
        rst_n = 1'b1;
        cycles(5);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/key_sw_conditioner.md
KEY_SW_CONDITIONER -- requirements
Module: key_sw_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized cycles required before a key state change is accepted (range 2..65535).
REQ-002 Parameter REPEAT_DELAY, default 16: held cycles after acceptance before the first auto-repeat pulse (used only with KEY_REPEAT_EN).
REQ-003 Parameter REPEAT_PERIOD, default 8: cycles between subsequent auto-repeat pulses (used only with KEY_REPEAT_EN).
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 KEY  input  4  raw push-buttons, active-low (0 = pressed), asynchronous to clk.
REQ-007 SW  input  10  raw slide switches, asynchronous to clk.
REQ-008 sw_sync  output  10  SW after a two-flop synchronizer; feeds the computer's SW input.
REQ-009 key_level  output  4  debounced key state, active-high (1 = pressed).
REQ-010 key_press  output  4  one-cycle pulse per accepted press (plus repeats when enabled).
REQ-011 key_release  output  4  one-cycle pulse per accepted release.

Function
REQ-012 Each KEY and SW bit shall pass through an independent two-flop synchronizer; sw_sync shall equal SW delayed by exactly 2 rising edges, with no further filtering.
REQ-013 Each key shall have an independent FSM with states RELEASED, CHECK_PRESS, PRESSED, CHECK_RELEASE and a counter of width ceil(log2(DEBOUNCE_CYCLES))+1.
REQ-014 RELEASED: synchronized key low -> CHECK_PRESS with counter = 1; otherwise stay, counter = 0.
REQ-015 CHECK_PRESS: synchronized key high -> RELEASED, counter = 0 (glitch rejected, no pulse); low and counter = DEBOUNCE_CYCLES-1 -> PRESSED; otherwise counter increments.
REQ-016 PRESSED/CHECK_RELEASE shall mirror REQ-014/REQ-015 with polarity inverted, returning to RELEASED on acceptance.
REQ-017 key_level shall be 1 in PRESSED and CHECK_RELEASE, 0 otherwise (registered, changes on the acceptance edge).
REQ-018 key_press shall be 1 for exactly the cycle after entering PRESSED from CHECK_PRESS; key_release 1 for exactly the cycle after entering RELEASED from CHECK_RELEASE.
REQ-019 Latency: a raw KEY edge held stable shall change key_level on the (DEBOUNCE_CYCLES+2)th rising edge after the first edge sampling the new value (6 edges at default).
REQ-020 Any bounce shorter than DEBOUNCE_CYCLES synchronized cycles shall produce no pulse and no key_level change.
REQ-021 Keys are independent: simultaneous presses on several keys shall produce pulses on all of them in the same cycle.
REQ-022 key_press and key_release of one key shall never be 1 in the same cycle.

Reset
REQ-023 While rst_n = 0: synchronizer flops for KEY = 1 (released), for SW = 0; all FSMs RELEASED; counters 0; key_level, key_press, key_release, sw_sync = 0.
REQ-024 Reset assertion mid-debounce or while held shall abort without emitting a pulse; a key held through reset deassertion shall be accepted as a fresh press after REQ-019 latency.

Configuration
REQ-025 Macro KEY_REPEAT_EN: when defined, a key remaining in PRESSED shall re-pulse key_press REPEAT_DELAY cycles after acceptance and then every REPEAT_PERIOD cycles until leaving PRESSED; repeat counter clears on any exit from PRESSED and on reset.
REQ-026 Without KEY_REPEAT_EN: no repeat logic synthesized; exactly one key_press per accepted press regardless of hold time; REPEAT_DELAY/REPEAT_PERIOD ignored.

Verification
REQ-027 Reset: rst_n=0 with KEY=4'b0000, SW=10'h3FF -> all outputs 0; after release, sw_sync=10'h3FF 2 edges later, key_level=4'hF on edge 6, key_press=4'hF for 1 cycle.
REQ-028 Clean press: KEY[0] 1->0 held 20 cycles (defaults) -> key_level[0] rises on edge 6, single key_press[0] pulse; release -> key_release[0] pulse on edge 6 after release.
REQ-029 Bounce: KEY[1] low for 3 cycles then high -> key_level[1], key_press[1], key_release[1] stay 0 throughout.
REQ-030 Mid-debounce reset: KEY[2] low 4 cycles, rst_n pulsed low 1 cycle -> no key_press[2]; key still low -> press accepted 6 edges after rst_n rises.
REQ-031 KEY_REPEAT_EN defined, KEY[3] held 40 cycles -> key_press[3] pulses at acceptance, +16, +24, +32 cycles; undefined -> only the acceptance pulse.
REQ-032 Switch path: SW toggled 10'h155 -> 10'h2AA -> sw_sync follows exactly 2 edges later, unaffected by key activity.
